rc4_nibble_decrypt: RTL and testbench

Receive-side RC4 engine for the 4-bit (16-entry S-box) cipher datapath. It holds a loadable key and runs the key-scheduling pass (init plus KSA) itself. It then regenerates the same keystream nibbles that the encrypt-side top produces and XORs each incoming ciphertext nibble to recover plaintext. It sits at the link output and replaces the external S/K array loading and write-back path with one self-contained, handshaked block.

---
 rtl/rc4_nibble_decrypt.sv | 164 ++++++++++++++++
 tb/tb_rc4_nibble_decrypt.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_nibble_decrypt.sv
// ---------------------------------------------------------------------------
// rc4_nibble_decrypt
//   Receive-side RC4 engine for the 4-bit (16-entry S-box) cipher datapath.
//   Holds a loadable key, runs the S-box init and key-scheduling passes
//   itself, then regenerates the encrypt-side keystream and XORs it onto each
//   accepted ciphertext nibble. Plaintext leaves on a registered valid/ready
//   output stage.
//
// Ports
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-low reset, clears all state
//   key_we     key nibble write strobe (honoured in IDLE and READY only)
//   key_addr   key nibble address
//   key_din    key nibble data
//   start      single-cycle pulse: (re)key and run init + KSA
//   busy       high while INIT or KSA is running
//   key_done   high in READY (keystream available)
//   ct_valid   ciphertext nibble valid
//   ct_data    ciphertext nibble
//   ct_ready   block accepts a ciphertext nibble this cycle
//   pt_valid   plaintext nibble valid (registered)
//   pt_data    plaintext nibble = ct_data ^ keystream
//   pt_ready   downstream accepts the plaintext nibble
//   ks_data    keystream nibble used for the current pt_data (debug)
// ---------------------------------------------------------------------------
module rc4_nibble_decrypt #(
  parameter int KEY_LEN = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_we,
  input  logic [3:0] key_addr,
  input  logic [3:0] key_din,
  input  logic       start,
  output logic       busy,
  output logic       key_done,
  input  logic       ct_valid,
  input  logic [3:0] ct_data,
  output logic       ct_ready,
  output logic       pt_valid,
  output logic [3:0] pt_data,
  input  logic       pt_ready,
  output logic [3:0] ks_data
);

  typedef enum logic [1:0] {IDLE, INIT, KSA, READY} state_t;

  localparam logic [3:0] KX_LAST = 4'(KEY_LEN - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_s [16];
  logic [3:0] r_k [16];
  logic [3:0] r_i, r_j, r_kx;
  logic       r_pt_valid;
  logic [3:0] r_pt_data, r_ks_data;

  // KSA step
  logic [3:0] w_ksa_j;
  // Keystream step (one accepted nibble)
  logic [3:0] w_i1, w_si, w_j1, w_sj, w_ks_idx, w_ks;
  logic       w_accept, w_drain;

  assign w_ksa_j  = r_j + r_s[r_i] + r_k[r_kx];

  assign w_i1     = r_i + 4'd1;
  assign w_si     = r_s[w_i1];
  assign w_j1     = r_j + w_si;
  assign w_sj     = r_s[w_j1];
  assign w_ks_idx = w_si + w_sj;

  // The keystream lookup must see the S-box after the swap, which is only
  // written at the clock edge; forward the two swapped entries here instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_ks = r_s[w_ks_idx];
    if (w_ks_idx == w_i1)      w_ks = w_sj;
    else if (w_ks_idx == w_j1) w_ks = w_si;
  end

  assign busy     = (r_state == INIT) || (r_state == KSA);
  assign key_done = (r_state == READY);
  assign ct_ready = (r_state == READY) && (!r_pt_valid || pt_ready);
  assign pt_valid = r_pt_valid;
  assign pt_data  = r_pt_data;
  assign ks_data  = r_ks_data;

  // A start in READY takes priority over a ciphertext handshake in that cycle.
  assign w_accept = ct_valid && ct_ready && !start;
  assign w_drain  = r_pt_valid && pt_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start)        w_state_nxt = INIT;
      INIT:    if (r_i == 4'hF)  w_state_nxt = KSA;
      KSA:     if (r_i == 4'hF)  w_state_nxt = READY;
      READY:   if (start)        w_state_nxt = INIT;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: S and K are small register arrays that must read as zero after
      // reset, so they are cleared here rather than mapped to a RAM macro.
      for (int n = 0; n < 16; n++) begin
        r_s[n] <= '0;
        r_k[n] <= '0;
      end
      r_i        <= '0;
      r_j        <= '0;
      r_kx       <= '0;
      r_pt_valid <= 1'b0;
      r_pt_data  <= '0;
      r_ks_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (key_we) r_k[key_addr] <= key_din;
          if (start)  r_i <= '0;
        end
        INIT: begin
          r_s[r_i] <= r_i;
          r_i      <= r_i + 4'd1;  // wraps to 0 for KSA
          r_j      <= '0;
          r_kx     <= '0;
        end
        KSA: begin
          // NOTE: non-blocking assignments both read the pre-edge values, so
          // this pair is a true swap (and a no-op when the indices coincide).
          r_s[r_i]     <= r_s[w_ksa_j];
          r_s[w_ksa_j] <= r_s[r_i];
          r_i          <= r_i + 4'd1;  // wraps to 0 for READY
          r_j          <= (r_i == 4'hF) ? 4'd0 : w_ksa_j;
          r_kx         <= (r_kx == KX_LAST) ? 4'd0 : r_kx + 4'd1;
        end
        READY: begin
          if (key_we) r_k[key_addr] <= key_din;
          if (start) begin
            r_pt_valid <= 1'b0;
            r_i        <= '0;
          end else if (w_accept) begin
            r_s[w_i1]  <= w_sj;
            r_s[w_j1]  <= w_si;
            r_i        <= w_i1;
            r_j        <= w_j1;
            r_pt_data  <= ct_data ^ w_ks;
            r_ks_data  <= w_ks;
            r_pt_valid <= 1'b1;
          end else if (w_drain) begin
            r_pt_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_nibble_decrypt.sv
// ---------------------------------------------------------------------------
// tb_rc4_nibble_decrypt
//   Directed bench for rc4_nibble_decrypt (KEY_LEN = 3). A behavioural RC4
//   model supplies the expected keystream; expected plaintext/keystream pairs
//   are queued on each ciphertext handshake and compared on each plaintext
//   handshake. Known-answer constants cover the all-zero key.
// ---------------------------------------------------------------------------
module tb_rc4_nibble_decrypt;

  localparam int KLEN = 3;

  logic       clk = 1'b0;
  logic       reset, key_we, start, ct_valid, pt_ready;
  logic [3:0] key_addr, key_din, ct_data;
  logic       busy, key_done, ct_ready, pt_valid;
  logic [3:0] pt_data, ks_data;

  rc4_nibble_decrypt #(.KEY_LEN(KLEN)) dut (
    .clk      (clk),
    .reset    (reset),
    .key_we   (key_we),
    .key_addr (key_addr),
    .key_din  (key_din),
    .start    (start),
    .busy     (busy),
    .key_done (key_done),
    .ct_valid (ct_valid),
    .ct_data  (ct_data),
    .ct_ready (ct_ready),
    .pt_valid (pt_valid),
    .pt_data  (pt_data),
    .pt_ready (pt_ready),
    .ks_data  (ks_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pt;
    logic [3:0] ks;
  } exp_t;

  int         n_cmp  = 0;
  int         n_fail = 0;
  exp_t       sb_q[$];
  logic [3:0] m_s [16];
  logic [3:0] m_k [16];
  logic [3:0] m_i, m_j;
  logic [3:0] pt_vec [40];
  logic [3:0] enc_ks [40];
  logic [3:0] cur_pt;
  bit         use_cur_pt = 1'b0;
  bit         last_acc   = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference key schedule using the model key m_k and KLEN.
  task automatic model_ksa();
    logic [3:0] j, t;
    for (int n = 0; n < 16; n++) m_s[n] = 4'(n);
    j = 4'd0;
    for (int n = 0; n < 16; n++) begin
      j = j + m_s[n] + m_k[n % KLEN];
      t = m_s[n]; m_s[n] = m_s[j]; m_s[j] = t;
    end
    m_i = 4'd0;
    m_j = 4'd0;
  endtask

  task automatic model_ks(output logic [3:0] k);
    logic [3:0] t, x;
    m_i = m_i + 4'd1;
    m_j = m_j + m_s[m_i];
    t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
    x = m_s[m_i] + m_s[m_j];
    k = m_s[x];
  endtask

  // One clock: score the handshakes that occur at the coming edge, then
  // advance to just after it.
  task automatic tick();
    exp_t       e;
    logic [3:0] k;
    #1;
    last_acc = 1'b0;
    if (pt_valid && pt_ready) begin
      check("sb_pending", 8'(sb_q.size() != 0), 8'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_pt", 8'(pt_data), 8'(e.pt));
        check("sb_ks", 8'(ks_data), 8'(e.ks));
      end
    end
    if (ct_valid && ct_ready) begin
      model_ks(k);
      e.ks = k;
      e.pt = use_cur_pt ? cur_pt : (ct_data ^ k);
      sb_q.push_back(e);
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Start pulse plus full init+KSA; key_done must rise exactly 32 edges later.
  task automatic rekey();
    start = 1'b1;
    tick();
    start = 1'b0;
    sb_q.delete();
    check("rekey_busy", 8'(busy), 8'd1);
    check("rekey_done_low", 8'(key_done), 8'd0);
    check("rekey_pt_valid", 8'(pt_valid), 8'd0);
    model_ksa();
    repeat (31) tick();
    check("rekey_done_31", 8'(key_done), 8'd0);
    tick();
    check("rekey_done_32", 8'(key_done), 8'd1);
  endtask

  initial begin
    int idx;
    reset = 1'b0; key_we = 1'b0; key_addr = '0; key_din = '0;
    start = 1'b0; ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b1;
    for (int n = 0; n < 16; n++) m_k[n] = 4'd0;

    // Reset values
    #12;
    check("rst_busy",     8'(busy),     8'd0);
    check("rst_key_done", 8'(key_done), 8'd0);
    check("rst_ct_ready", 8'(ct_ready), 8'd0);
    check("rst_pt_valid", 8'(pt_valid), 8'd0);
    check("rst_pt_data",  8'(pt_data),  8'd0);
    check("rst_ks_data",  8'(ks_data),  8'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Zero key; a start pulse mid-KSA must not restart the schedule
    start = 1'b1;
    tick();                       // edge 0
    start = 1'b0;
    model_ksa();
    repeat (19) tick();           // edges 1..19
    check("busy_in_ksa", 8'(busy), 8'd1);
    start = 1'b1;
    tick();                       // edge 20, ignored
    start = 1'b0;
    repeat (11) tick();           // edges 21..31
    check("done_at_31", 8'(key_done), 8'd0);
    check("busy_at_31", 8'(busy), 8'd1);
    tick();                       // edge 32
    check("done_at_32", 8'(key_done), 8'd1);
    check("busy_at_32", 8'(busy), 8'd0);
    check("ct_ready_at_32", 8'(ct_ready), 8'd1);

    // Back-to-back zero ciphertext -> 8, F, 6
    ct_valid = 1'b1; ct_data = 4'h0; pt_ready = 1'b1;
    tick();
    check("b2b_valid", 8'(pt_valid), 8'd1);
    check("b2b_pt0", 8'(pt_data), 8'h8);
    check("b2b_ks0", 8'(ks_data), 8'h8);
    tick();
    check("b2b_pt1", 8'(pt_data), 8'hF);
    check("b2b_ks1", 8'(ks_data), 8'hF);
    tick();
    check("b2b_pt2", 8'(pt_data), 8'h6);
    check("b2b_ks2", 8'(ks_data), 8'h6);
    ct_valid = 1'b0;
    tick();
    check("b2b_drained", 8'(pt_valid), 8'd0);

    // Backpressure: F, A, 6 with a 3-cycle stall after the first
    rekey();
    ct_valid = 1'b1; ct_data = 4'hF;
    tick();
    check("bp_pt0", 8'(pt_data), 8'h7);
    pt_ready = 1'b0; ct_data = 4'hA;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("bp_ct_ready", 8'(ct_ready), 8'd0);
      tick();
      check("bp_hold_valid", 8'(pt_valid), 8'd1);
      check("bp_hold_pt", 8'(pt_data), 8'h7);
    end
    pt_ready = 1'b1;
    tick();
    check("bp_pt1", 8'(pt_data), 8'h5);
    ct_data = 4'h6;
    tick();
    check("bp_pt2", 8'(pt_data), 8'h0);
    ct_valid = 1'b0;
    tick();

    // Start in READY with a pending nibble: it is dropped, keystream restarts
    ct_valid = 1'b1; ct_data = 4'h0; pt_ready = 1'b0;
    tick();
    ct_valid = 1'b0;
    check("pend_valid", 8'(pt_valid), 8'd1);
    rekey();
    pt_ready = 1'b1;
    ct_valid = 1'b1; ct_data = 4'h0;
    tick();
    check("restart_pt", 8'(pt_data), 8'h8);
    ct_valid = 1'b0;
    tick();

    // Async reset at KSA iteration 7 (key written in READY first)
    for (int n = 0; n < KLEN; n++) begin
      key_we = 1'b1; key_addr = 4'(n); key_din = 4'(n + 1);
      tick();
    end
    key_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16 + 7) tick();
    check("pre_rst_busy", 8'(busy), 8'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_busy",     8'(busy),     8'd0);
    check("arst_key_done", 8'(key_done), 8'd0);
    check("arst_pt_valid", 8'(pt_valid), 8'd0);
    check("arst_ct_ready", 8'(ct_ready), 8'd0);
    check("arst_pt_data",  8'(pt_data),  8'd0);
    sb_q.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Reload key 1,2,3; ct_valid and key writes during INIT/KSA are ignored
    for (int n = 0; n < KLEN; n++) begin
      key_we = 1'b1; key_addr = 4'(n); key_din = 4'(n + 1);
      m_k[n] = 4'(n + 1);
      tick();
    end
    key_we = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ct_valid = 1'b1; ct_data = 4'h5;
    key_we = 1'b1; key_addr = 4'h0; key_din = 4'hF;
    #1;
    check("busy_ct_ready", 8'(ct_ready), 8'd0);
    repeat (20) tick();
    ct_valid = 1'b0; key_we = 1'b0;
    repeat (11) tick();
    check("reload_done_31", 8'(key_done), 8'd0);
    tick();
    check("reload_done_32", 8'(key_done), 8'd1);
    check("reload_pt_valid", 8'(pt_valid), 8'd0);

    // Loopback: encrypt-side keystream, 40 nibbles with random stalls
    model_ksa();
    for (int n = 0; n < 40; n++) model_ks(enc_ks[n]);
    model_ksa();
    for (int n = 0; n < 40; n++) pt_vec[n] = 4'($urandom_range(0, 15));
    use_cur_pt = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 400 && idx < 40; cyc++) begin
      pt_ready = ($urandom_range(0, 3) != 0);
      ct_valid = ($urandom_range(0, 3) != 0);
      cur_pt   = pt_vec[idx];
      ct_data  = pt_vec[idx] ^ enc_ks[idx];
      tick();
      if (last_acc) idx++;
    end
    check("loop_count", 8'(idx), 8'd40);
    ct_valid = 1'b0; pt_ready = 1'b1;
    tick();
    tick();
    check("loop_sb_empty", 8'(sb_q.size()), 8'd0);
    check("loop_idle_valid", 8'(pt_valid), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
